cram_arbiter: RTL and testbench
===============================

# cram_arbiter

Single-port arbiter and sequencer in front of the cartridge RAM. It sits between the mapper outputs (CPU-side cart RAM address and data, plus mapper-direct writes such as the EEPROM write-back) and the backup/save-file interface. It shares the one byte-wide RAM port among three requesters with fixed priority and splits 16-bit backup words into two byte accesses. Read data is routed back to the originating requester through a tagged pipeline.

## Interface
Parameters:
- AW, 17, cart RAM byte-address width
- RAM_LAT, 1, clk_sys cycles from ram_addr presented to ram_q valid (1 or 2 supported)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- ce_cpu  in  1  CPU clock enable; CPU requests are qualified by it
- cpu_rd  in  1  CPU read request (sampled when ce_cpu=1)
- cpu_wr  in  1  CPU write request (sampled when ce_cpu=1)
- cpu_addr  in  AW  CPU byte address (mapper-translated)
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data, held until next CPU read completes
- map_wr  in  1  mapper-direct write strobe, one cycle
- map_addr  in  AW  mapper-direct address
- map_di  in  8  mapper-direct data
- bk_rd  in  1  backup word read request, level, held until bk_ack
- bk_wr  in  1  backup word write request, level, held until bk_ack
- bk_addr  in  AW-1  backup word address
- bk_di  in  16  backup write word, low byte at even address
- bk_do  out  16  backup read word, valid while bk_ack=1
- bk_ack  out  1  one-cycle completion pulse
- ram_addr  out  AW  RAM byte address, registered
- ram_d  out  8  RAM write data, registered
- ram_wr  out  1  RAM write strobe, registered, one cycle per byte
- ram_q  in  8  RAM read data
- map_ovf  out  1  sticky: mapper write overwritten while pending; cleared by reset only

## Operation
- One RAM slot per clk_sys. Priority per slot: CPU > pending mapper write > backup sequencer.
- CPU: a request seen with ce_cpu=1 is issued in the next slot unconditionally. If cpu_rd and cpu_wr are both set, it is treated as a write.
- Mapper: map_wr loads a one-entry buffer (addr, data, valid). The buffer drains in the first slot not taken by the CPU. A map_wr while valid=1 overwrites the buffer and sets map_ovf. A map_wr arriving in the same cycle the buffer drains fills it again.
- Backup sequencer (sub-module) states: IDLE, LO, HI, RDWAIT, ACK, RELEASE.
  - IDLE: samples bk_wr (takes precedence) or bk_rd, latches address and data, goes to LO.
  - LO issues byte address {bk_addr,0}; HI issues {bk_addr,1}. Each state advances only when it wins a slot and otherwise stalls.
  - Write: HI goes to ACK. Read: HI goes to RDWAIT, which waits for the HI byte to return, then goes to ACK.
  - ACK: bk_ack=1 for one cycle, then RELEASE.
  - RELEASE waits for bk_rd=bk_wr=0, then returns to IDLE. This prevents double-issue.
- Return path: each issued slot pushes a tag {NONE, CPU_RD, BK_LO, BK_HI} into a RAM_LAT+1 deep shift register. At the tail, ram_q is written to cpu_do, bk_do[7:0] or bk_do[15:8].
- Idle slots: ram_wr=0 and ram_addr holds its last value.

## Timing
- Reset (asynchronous, immediate):
  - ram_wr=0, ram_addr=0, ram_d=0
  - cpu_do=8'hFF, bk_do=0, bk_ack=0, map_ovf=0
  - FSM=IDLE, mapper buffer invalid, all tags NONE
- Reset mid-sequence abandons any word in flight; no ack is produced.
- CPU write: request edge N; ram_wr=1 during cycle N+1.
- CPU read: ram_addr presented in N+1; cpu_do is valid from N+2+RAM_LAT. This is 3 cycles at RAM_LAT=1.
- Requirement: ce_cpu pulses are at least 4 clk_sys apart. Under that rule the CPU never starves the other requesters, so the mapper buffer drains within 1 slot of any CPU slot.
- Backup write, uncontended: request edge N; LO slot at N+1, HI slot at N+2; bk_ack at N+3.
- Backup read, uncontended: bk_ack at N+3+RAM_LAT. bk_do holds its value after ack until the next backup read.

## Structure
- Package gb_cram_pkg holds:
  - slot-tag enum {NONE, CPU_RD, BK_LO, BK_HI}
  - backup FSM state enum
  - AW default and the 8'hFF open-bus constant
- Sub-module cram_bk_seq: backup FSM plus word latch. It exposes a slot request (req, addr, data, we) and a grant input.
- The top level contains the priority mux, mapper buffer, tag shift register, and output registers.

## Test plan
- Reset, then CPU read of 0x00005 with RAM byte 0x3C: ram_addr=0x00005 one cycle after the ce_cpu edge; cpu_do=0x3C three cycles after the edge. Before any read, cpu_do=0xFF.
- Backup write bk_addr=0x0010, bk_di=0xBEEF, uncontended: ram writes 0x00020←0xEF and 0x00021←0xBE on consecutive cycles; single bk_ack pulse; no re-issue while the request is held.
- Backup read of the same word with a CPU write landing on the LO slot: LO stalls one cycle, the CPU write goes first, bk_do=0xBEEF at ack.
- map_wr twice back-to-back while a CPU access holds the slot: only the second value is written, map_ovf=1; a map_wr after the drain leaves map_ovf unchanged.
- bk_rd=bk_wr=1 at once: write executes. reset_n pulled low between LO and HI: ram_wr drops immediately, no bk_ack, FSM=IDLE after release.

Source files
------------

// File: rtl/gb_cram_pkg.sv
// gb_cram_pkg: shared types and constants for the cartridge RAM arbiter.
//   tag_e      - what a RAM slot was issued for, carried down the return pipeline
//   bk_state_e - backup word sequencer states
//   CRAM_AW    - default cart RAM byte-address width
//   OPEN_BUS   - value the CPU sees before any read has completed
package gb_cram_pkg;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CPU_RD,
        TAG_BK_LO,
        TAG_BK_HI
    } tag_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_RDWAIT,
        S_ACK,
        S_RELEASE
    } bk_state_e;

    localparam int CRAM_AW = 17;
    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/cram_bk_seq.sv
// cram_bk_seq: splits a 16-bit backup word access into two byte slots.
//   clk_sys, reset_n  - clock, async active-low reset
//   bk_rd, bk_wr      - level word requests, held until acknowledged
//   bk_addr, bk_di    - word address and write word (low byte at even address)
//   grant             - this cycle's slot goes to the sequencer if it requests
//   hi_due            - the high byte of a read returns on the next capture edge
//   req, addr, data, we - slot request presented to the arbiter
//   ack               - high for the single ACK state cycle
module cram_bk_seq
    import gb_cram_pkg::*;
#(
    parameter int AW = CRAM_AW
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          bk_rd,
    input  logic          bk_wr,
    input  logic [AW-2:0] bk_addr,
    input  logic [15:0]   bk_di,
    input  logic          grant,
    input  logic          hi_due,
    output logic          req,
    output logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          we,
    output logic          ack
);

    bk_state_e state, state_nx;
    logic [AW-2:0] wa;
    logic [15:0]   wd;
    logic          wwe;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            wa    <= '0;
            wd    <= '0;
            wwe   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && (bk_rd || bk_wr)) begin
                wa  <= bk_addr;
                wd  <= bk_di;
                wwe <= bk_wr;
            end
        end
    end

    // IDLE presents the low byte straight from the request inputs, so an
    // uncontended word occupies the two slots right after the request edge.
    // If that slot is lost, LO retries from the latched copy.
    always_comb begin
        state_nx = state;
        req      = 1'b0;
        addr     = {wa, 1'b0};
        data     = wd[7:0];
        we       = wwe;
        case (state)
            S_IDLE: if (bk_rd || bk_wr) begin
                req      = 1'b1;
                addr     = {bk_addr, 1'b0};
                data     = bk_di[7:0];
                we       = bk_wr;
                state_nx = grant ? S_HI : S_LO;
            end
            S_LO: begin
                req      = 1'b1;
                state_nx = grant ? S_HI : S_LO;
            end
            S_HI: begin
                req      = 1'b1;
                addr     = {wa, 1'b1};
                data     = wd[15:8];
                state_nx = grant ? (wwe ? S_ACK : S_RDWAIT) : S_HI;
            end
            S_RDWAIT:  state_nx = hi_due ? S_ACK : S_RDWAIT;
            S_ACK:     state_nx = S_RELEASE;
            S_RELEASE: state_nx = (bk_rd || bk_wr) ? S_RELEASE : S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    assign ack = state == S_ACK;

endmodule

// File: rtl/cram_arbiter.sv
// cram_arbiter: single-port cart RAM arbiter (CPU > mapper buffer > backup).
//   clk_sys, reset_n         - clock, async active-low reset
//   ce_cpu, cpu_rd, cpu_wr, cpu_addr, cpu_di, cpu_do - CPU side
//   map_wr, map_addr, map_di - mapper-direct write strobe into a one-entry buffer
//   bk_rd, bk_wr, bk_addr, bk_di, bk_do, bk_ack - backup word interface
//   ram_addr, ram_d, ram_wr, ram_q - registered byte-wide RAM port
//   map_ovf                  - sticky, a buffered mapper write was overwritten
module cram_arbiter
    import gb_cram_pkg::*;
#(
    parameter int AW      = CRAM_AW,
    parameter int RAM_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce_cpu,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_di,
    output logic [7:0]    cpu_do,
    input  logic          map_wr,
    input  logic [AW-1:0] map_addr,
    input  logic [7:0]    map_di,
    input  logic          bk_rd,
    input  logic          bk_wr,
    input  logic [AW-2:0] bk_addr,
    input  logic [15:0]   bk_di,
    output logic [15:0]   bk_do,
    output logic          bk_ack,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_d,
    output logic          ram_wr,
    input  logic [7:0]    ram_q,
    output logic          map_ovf
);

    logic          cpu_req, map_v, bk_req, bk_we, bk_grant, bk_ack_s, hi_due;
    logic [AW-1:0] map_a, bk_sa;
    logic [7:0]    map_d, bk_sd;
    tag_e          tag_in;
    tag_e          tag_q [RAM_LAT+1];

    assign cpu_req  = ce_cpu & (cpu_rd | cpu_wr);
    assign bk_grant = ~cpu_req & ~map_v;
    // Looking one stage ahead of the tail lets the registered bk_ack rise
    // together with the captured high byte.
    assign hi_due   = tag_q[RAM_LAT-1] == TAG_BK_HI;

    // A simultaneous rd+wr from the CPU is a write, so it carries no tag.
    always_comb begin
        tag_in = TAG_NONE;
        if (cpu_req)
            tag_in = cpu_wr ? TAG_NONE : TAG_CPU_RD;
        else if (!map_v && bk_req && !bk_we)
            tag_in = bk_sa[0] ? TAG_BK_HI : TAG_BK_LO;
    end

    cram_bk_seq #(.AW(AW)) u_seq (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bk_rd   (bk_rd),
        .bk_wr   (bk_wr),
        .bk_addr (bk_addr),
        .bk_di   (bk_di),
        .grant   (bk_grant),
        .hi_due  (hi_due),
        .req     (bk_req),
        .addr    (bk_sa),
        .data    (bk_sd),
        .we      (bk_we),
        .ack     (bk_ack_s)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_d    <= '0;
            cpu_do   <= OPEN_BUS;
            bk_do    <= '0;
            bk_ack   <= 1'b0;
            map_ovf  <= 1'b0;
            map_v    <= 1'b0;
            map_a    <= '0;
            map_d    <= '0;
            for (int i = 0; i <= RAM_LAT; i++) tag_q[i] <= TAG_NONE;
        end else begin
            // The buffer drains in any slot the CPU leaves free; a strobe in
            // that same cycle refills it and is not an overflow.
            map_v <= map_wr | (map_v & cpu_req);
            if (map_wr) begin
                map_a <= map_addr;
                map_d <= map_di;
            end
            if (map_wr && map_v && cpu_req) map_ovf <= 1'b1;
            ram_wr <= cpu_req ? cpu_wr : (map_v | (bk_req & bk_we));
            if (cpu_req) begin
                ram_addr <= cpu_addr;
                ram_d    <= cpu_di;
            end else if (map_v) begin
                ram_addr <= map_a;
                ram_d    <= map_d;
            end else if (bk_req) begin
                ram_addr <= bk_sa;
                ram_d    <= bk_sd;
            end
            tag_q[0] <= tag_in;
            for (int i = 1; i <= RAM_LAT; i++) tag_q[i] <= tag_q[i-1];
            if (tag_q[RAM_LAT] == TAG_CPU_RD) cpu_do <= ram_q;
            if (tag_q[RAM_LAT] == TAG_BK_LO) bk_do[7:0] <= ram_q;
            if (tag_q[RAM_LAT] == TAG_BK_HI) bk_do[15:8] <= ram_q;
            bk_ack <= bk_ack_s;
        end
    end

endmodule

// File: tb/tb_cram_arbiter.sv
// tb_cram_arbiter: directed, table-driven bench for cram_arbiter with a
// behavioural single-cycle-latency RAM model attached to the RAM port.
module tb_cram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_cpu = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [7:0]  cpu_di = '0;
    logic [7:0]  cpu_do;
    logic        map_wr = 1'b0;
    logic [16:0] map_addr = '0;
    logic [7:0]  map_di = '0;
    logic        bk_rd = 1'b0, bk_wr = 1'b0;
    logic [15:0] bk_addr = '0;
    logic [15:0] bk_di = '0;
    logic [15:0] bk_do;
    logic        bk_ack;
    logic [16:0] ram_addr;
    logic [7:0]  ram_d;
    logic        ram_wr;
    logic [7:0]  ram_q = '0;
    logic        map_ovf;

    logic [7:0]  mem [0:(1<<17)-1];
    int          n_pass = 0, n_total = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_wr) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    cram_arbiter #(.AW(17), .RAM_LAT(1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ce_cpu(ce_cpu), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do),
        .map_wr(map_wr), .map_addr(map_addr), .map_di(map_di),
        .bk_rd(bk_rd), .bk_wr(bk_wr), .bk_addr(bk_addr), .bk_di(bk_di),
        .bk_do(bk_do), .bk_ack(bk_ack),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_wr(ram_wr), .ram_q(ram_q),
        .map_ovf(map_ovf)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [16:0] addr;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [7];
        int   cnt, acks, wrs;
        vt[0] = '{rd: 1'b0, wr: 1'b1, addr: 17'h00001, d: 8'hA1, exp: 8'h00};
        vt[1] = '{rd: 1'b0, wr: 1'b1, addr: 17'h1FFFF, d: 8'h7E, exp: 8'h00};
        vt[2] = '{rd: 1'b1, wr: 1'b1, addr: 17'h00002, d: 8'hC3, exp: 8'h00};
        vt[3] = '{rd: 1'b1, wr: 1'b0, addr: 17'h00001, d: 8'h00, exp: 8'hA1};
        vt[4] = '{rd: 1'b1, wr: 1'b0, addr: 17'h1FFFF, d: 8'h00, exp: 8'h7E};
        vt[5] = '{rd: 1'b1, wr: 1'b0, addr: 17'h00002, d: 8'h00, exp: 8'hC3};
        vt[6] = '{rd: 1'b1, wr: 1'b0, addr: 17'h00005, d: 8'h00, exp: 8'h3C};
        mem[17'h00005] = 8'h3C;

        // reset state
        idle(2);
        chk("rst ram_wr", ram_wr, 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_d", ram_d, 0);
        chk("rst cpu_do", cpu_do, 8'hFF);
        chk("rst bk_do", bk_do, 0);
        chk("rst bk_ack", bk_ack, 0);
        chk("rst map_ovf", map_ovf, 0);
        reset_n = 1'b1;
        idle(2);

        // CPU read of 0x00005 with exact latency
        ce_cpu = 1; cpu_rd = 1; cpu_addr = 17'h00005;
        tick();
        ce_cpu = 0; cpu_rd = 0;
        chk("cpu rd addr N+1", ram_addr, 17'h00005);
        chk("cpu rd no wr", ram_wr, 0);
        tick();
        chk("cpu_do open bus N+2", cpu_do, 8'hFF);
        tick();
        chk("cpu_do N+3", cpu_do, 8'h3C);
        idle(2);

        // table-driven CPU writes and reads
        foreach (vt[k]) begin
            ce_cpu = 1; cpu_rd = vt[k].rd; cpu_wr = vt[k].wr;
            cpu_addr = vt[k].addr; cpu_di = vt[k].d;
            tick();
            ce_cpu = 0; cpu_rd = 0; cpu_wr = 0;
            chk($sformatf("vec%0d ram_addr", k), ram_addr, vt[k].addr);
            chk($sformatf("vec%0d ram_wr", k), ram_wr, vt[k].wr);
            if (vt[k].wr) chk($sformatf("vec%0d ram_d", k), ram_d, vt[k].d);
            tick();
            chk($sformatf("vec%0d wr one cycle", k), ram_wr, 0);
            tick();
            if (!vt[k].wr) chk($sformatf("vec%0d cpu_do", k), cpu_do, vt[k].exp);
            tick();
        end

        // backup write 0x0010 <- 0xBEEF, uncontended
        bk_wr = 1; bk_addr = 16'h0010; bk_di = 16'hBEEF;
        tick();
        chk("bkw lo wr", ram_wr, 1);
        chk("bkw lo addr", ram_addr, 17'h00020);
        chk("bkw lo data", ram_d, 8'hEF);
        chk("bkw no early ack", bk_ack, 0);
        tick();
        chk("bkw hi wr", ram_wr, 1);
        chk("bkw hi addr", ram_addr, 17'h00021);
        chk("bkw hi data", ram_d, 8'hBE);
        tick();
        chk("bkw ack N+3", bk_ack, 1);
        chk("bkw idle slot", ram_wr, 0);
        acks = 0; wrs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            acks += int'(bk_ack);
            wrs += int'(ram_wr);
        end
        chk("bkw held no reack", acks, 0);
        chk("bkw held no reissue", wrs, 0);
        bk_wr = 0;
        idle(2);

        // backup read of same word; CPU write lands on the LO slot
        bk_rd = 1; bk_addr = 16'h0010;
        ce_cpu = 1; cpu_wr = 1; cpu_addr = 17'h00100; cpu_di = 8'h5A;
        tick();
        ce_cpu = 0; cpu_wr = 0;
        chk("bkr cpu first wr", ram_wr, 1);
        chk("bkr cpu first addr", ram_addr, 17'h00100);
        tick();
        chk("bkr lo addr stalled", ram_addr, 17'h00020);
        chk("bkr lo no wr", ram_wr, 0);
        tick();
        chk("bkr hi addr", ram_addr, 17'h00021);
        cnt = 0;
        while (!bk_ack && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("bkr ack latency", cnt, 2);
        chk("bkr bk_do at ack", bk_do, 16'hBEEF);
        bk_rd = 0;
        tick();
        chk("bkr ack one cycle", bk_ack, 0);
        chk("bkr bk_do held", bk_do, 16'hBEEF);
        idle(3);

        // mapper: two strobes back-to-back, second one during a CPU slot
        map_wr = 1; map_addr = 17'h00200; map_di = 8'h11;
        tick();
        chk("map ovf clear", map_ovf, 0);
        map_addr = 17'h00201; map_di = 8'h22;
        ce_cpu = 1; cpu_rd = 1; cpu_addr = 17'h00005;
        tick();
        map_wr = 0; ce_cpu = 0; cpu_rd = 0;
        chk("map cpu slot addr", ram_addr, 17'h00005);
        chk("map cpu slot no wr", ram_wr, 0);
        chk("map ovf set", map_ovf, 1);
        tick();
        chk("map drain wr", ram_wr, 1);
        chk("map drain addr", ram_addr, 17'h00201);
        chk("map drain data", ram_d, 8'h22);
        tick();
        chk("map single drain", ram_wr, 0);
        map_wr = 1; map_addr = 17'h00202; map_di = 8'h33;
        tick();
        map_wr = 0;
        tick();
        chk("map2 drain addr", ram_addr, 17'h00202);
        chk("map2 drain data", ram_d, 8'h33);
        chk("map ovf sticky", map_ovf, 1);
        idle(3);

        // bk_rd and bk_wr together: write wins
        bk_rd = 1; bk_wr = 1; bk_addr = 16'h0030; bk_di = 16'h1234;
        tick();
        chk("both lo wr", ram_wr, 1);
        chk("both lo addr", ram_addr, 17'h00060);
        chk("both lo data", ram_d, 8'h34);
        tick();
        chk("both hi data", ram_d, 8'h12);
        tick();
        chk("both ack", bk_ack, 1);
        chk("both bk_do untouched", bk_do, 16'hBEEF);
        bk_rd = 0; bk_wr = 0;
        idle(3);

        // reset between LO and HI
        bk_wr = 1; bk_addr = 16'h0040; bk_di = 16'hA5C3;
        tick();
        chk("rstmid lo wr", ram_wr, 1);
        #2 reset_n = 0;
        #1;
        chk("rstmid ram_wr drop", ram_wr, 0);
        chk("rstmid ram_addr", ram_addr, 0);
        chk("rstmid bk_do", bk_do, 0);
        chk("rstmid map_ovf", map_ovf, 0);
        chk("rstmid cpu_do", cpu_do, 8'hFF);
        bk_wr = 0;
        idle(2);
        reset_n = 1;
        acks = 0; wrs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(bk_ack);
            wrs += int'(ram_wr);
        end
        chk("rstmid no ack", acks, 0);
        chk("rstmid no write", wrs, 0);
        bk_wr = 1; bk_addr = 16'h0041; bk_di = 16'h0102;
        tick();
        chk("after rst lo addr", ram_addr, 17'h00082);
        chk("after rst lo data", ram_d, 8'h02);
        tick();
        tick();
        chk("after rst ack", bk_ack, 1);
        bk_wr = 0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
